// File: rtl/matrix_uart_printer.sv
// Reads an m x n matrix (word 0 = m, word 1 = n, then row-major elements) from memory
// and streams it as ASCII decimal text. Define MATRIX_PRINT_HEADER_EN to prefix an "m n" line.
module matrix_uart_printer #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int MAX_DIM    = 5,
  parameter int MAX_DIGITS = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);
  localparam int DIM_W = $clog2(MAX_DIM + 1);
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [DATA_W-1:0] TEN     = DATA_W'(10);
  localparam logic [DATA_W-1:0] ONE     = DATA_W'(1);
  localparam logic [DATA_W-1:0] DIM_MAX = DATA_W'(MAX_DIM);

  typedef enum logic [3:0] {
    IDLE, RD_M, RD_N, CHECK, RD_ELEM, CONVERT,
    SEND_DIGIT, SEND_SEP, SEND_CR, SEND_LF, FINISH
  } state_t;

  typedef enum logic [1:0] {PH_ELEM, PH_HDR_M, PH_HDR_N} phase_t;

  state_t             state;
  phase_t             phase;
  logic [DIM_W-1:0]   row;
  logic [DIM_W-1:0]   col;
  logic [CNT_W-1:0]   dcnt;
  logic               rd_vld_p1;
  logic [DATA_W-1:0]  m_q;
  logic [DATA_W-1:0]  n_q;
  logic [DATA_W-1:0]  work;
  logic [3:0]         stack [MAX_DIGITS];

  logic               tx_acc;
  logic [DATA_W-1:0]  work_div;
  logic [CNT_W-1:0]   top_idx;
  logic               last_col;
  logic               last_row;
  logic               dims_bad;

  function automatic logic [3:0] low_digit(input logic [DATA_W-1:0] v);
    return 4'(v % TEN);
  endfunction

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  always_comb begin
    tx_acc   = tx_valid && tx_ready;
    work_div = work / TEN;
    top_idx  = dcnt - 1'b1;
    last_col = (DATA_W'(col) + ONE) == n_q;
    last_row = (DATA_W'(row) + ONE) == m_q;
    dims_bad = (m_q == '0) || (m_q > DIM_MAX) || (n_q == '0) || (n_q > DIM_MAX);
  end

  // Datapath registers carry no reset; the FSM decides when they are meaningful.
  always_ff @(posedge clk) begin
    if (state == RD_M && rd_vld_p1) m_q <= mem_rd_data;
    if (state == RD_N && rd_vld_p1) n_q <= mem_rd_data;
    if (state == RD_ELEM && rd_vld_p1) begin
      work <= mem_rd_data;
    end else if (state == CONVERT) begin
      stack[dcnt] <= low_digit(work);
      work        <= work_div;
    end
`ifdef MATRIX_PRINT_HEADER_EN
    else if (state == CHECK) begin
      work <= m_q;
    end else if (state == SEND_SEP && tx_acc && phase == PH_HDR_M) begin
      work <= n_q;
    end
`endif
  end

  // Reads are strictly sequential (m, n, then row-major elements), so each new
  // read address is the previous one plus one, wrapping naturally at 2^ADDR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      phase       <= PH_ELEM;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      row         <= '0;
      col         <= '0;
      dcnt        <= '0;
      rd_vld_p1   <= 1'b0;
    end else begin
      done      <= 1'b0;
      error     <= 1'b0;
      mem_rd_en <= 1'b0;
      rd_vld_p1 <= mem_rd_en;
      case (state)
        IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= base_addr;
            phase       <= PH_ELEM;
            state       <= RD_M;
          end
        end
        RD_M: begin
          if (rd_vld_p1) begin
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= mem_rd_addr + 1'b1;
            state       <= RD_N;
          end
        end
        RD_N: begin
          if (rd_vld_p1) state <= CHECK;
        end
        CHECK: begin
          row <= '0;
          col <= '0;
          if (dims_bad) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
`ifdef MATRIX_PRINT_HEADER_EN
            phase <= PH_HDR_M;
            dcnt  <= '0;
            state <= CONVERT;
`else
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= mem_rd_addr + 1'b1;
            state       <= RD_ELEM;
`endif
          end
        end
        RD_ELEM: begin
          if (rd_vld_p1) begin
            dcnt  <= '0;
            state <= CONVERT;
          end
        end
        CONVERT: begin
          dcnt <= dcnt + 1'b1;
          if (work_div == '0) state <= SEND_DIGIT;
        end
        SEND_DIGIT: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= ascii_digit(stack[top_idx]);
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
            dcnt     <= top_idx;
            if (top_idx == '0) begin
              if (phase == PH_HDR_M)      state <= SEND_SEP;
              else if (phase == PH_HDR_N) state <= SEND_CR;
              else if (last_col)          state <= SEND_CR;
              else                        state <= SEND_SEP;
            end
          end
        end
        SEND_SEP: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= 8'h20;
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
            if (phase == PH_HDR_M) begin
              phase <= PH_HDR_N;
              dcnt  <= '0;
              state <= CONVERT;
            end else begin
              col         <= col + 1'b1;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= mem_rd_addr + 1'b1;
              state       <= RD_ELEM;
            end
          end
        end
        SEND_CR: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= 8'h0D;
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= SEND_LF;
          end
        end
        SEND_LF: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= 8'h0A;
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
            if (phase == PH_HDR_N) begin
              phase       <= PH_ELEM;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= mem_rd_addr + 1'b1;
              state       <= RD_ELEM;
            end else if (last_row) begin
              state <= FINISH;
            end else begin
              row         <= row + 1'b1;
              col         <= '0;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= mem_rd_addr + 1'b1;
              state       <= RD_ELEM;
            end
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
